// File: rtl/control_module_pkg.sv
// ---------------------------------------------------------------------------
// control_module_pkg
// Shared definitions for the LED panel command decoder: the command-line
// state encoding and the ASCII command bytes understood by the decoder.
// ---------------------------------------------------------------------------
package control_module_pkg;

    // Command-line decoder states; the numeric codes are exported on the
    // debug port, so they must stay fixed.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ_ROW  = 2'd1,
        ST_READ_DATA = 2'd2,
        ST_READ_ARG  = 2'd3
    } cmdState_e;

    // Upper case turns a colour plane on, lower case turns it off.
    localparam logic [7:0] CMD_RED_ON    = 8'h52; // 'R'
    localparam logic [7:0] CMD_GREEN_ON  = 8'h47; // 'G'
    localparam logic [7:0] CMD_BLUE_ON   = 8'h42; // 'B'
    localparam logic [7:0] CMD_RED_OFF   = 8'h72; // 'r'
    localparam logic [7:0] CMD_GREEN_OFF = 8'h67; // 'g'
    localparam logic [7:0] CMD_BLUE_OFF  = 8'h62; // 'b'

    // 'T' takes one argument byte (brightness planes), 'L' takes a row
    // number followed by one full row of pixel bytes.
    localparam logic [7:0] CMD_BRIGHT    = 8'h54; // 'T'
    localparam logic [7:0] CMD_LINE      = 8'h4C; // 'L'

endpackage

// File: rtl/control_module.sv
// ---------------------------------------------------------------------------
// control_module
// Decodes a byte stream from a UART receiver into panel control settings
// and frame RAM writes.
//
// Ports:
//   clk_in             system clock
//   reset              synchronous active-high reset
//   data_rx            received byte, stable once data_ready_n falls
//   data_ready_n       receiver busy flag (already synchronised); its falling
//                      edge marks a new byte
//   rgb_enable         colour plane enables {R,G,B}
//   brightness_enable  brightness bit-plane enables
//   ram_data_out       byte written to frame RAM
//   ram_address        frame RAM address {row, byte column}
//   ram_write_enable   single-cycle write strobe
//   ram_clk_enable     frame RAM clock enable (off only while in reset)
//   ram_reset          frame RAM reset (reset delayed one cycle)
//   cmd_line_state2    DEBUGGER only: current decoder state code
//   num_commands_processed DEBUGGER only: completed command counter
// ---------------------------------------------------------------------------
module control_module
    import control_module_pkg::*;
#(
    parameter int PIXEL_WIDTH     = 64,
    parameter int PIXEL_HEIGHT    = 32,
    parameter int BYTES_PER_PIXEL = 2,
    localparam int AW = $clog2(PIXEL_HEIGHT) + $clog2(PIXEL_WIDTH*BYTES_PER_PIXEL - 1)
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic [7:0]    data_rx,
    input  logic          data_ready_n,
    output logic [2:0]    rgb_enable,
    output logic [5:0]    brightness_enable,
    output logic [7:0]    ram_data_out,
    output logic [AW-1:0] ram_address,
    output logic          ram_write_enable,
    output logic          ram_clk_enable,
    output logic          ram_reset
`ifdef DEBUGGER
    ,
    output logic [1:0]    cmd_line_state2,
    output logic [7:0]    num_commands_processed
`endif
);

    localparam int LB = PIXEL_WIDTH * BYTES_PER_PIXEL;
    localparam int RW = $clog2(PIXEL_HEIGHT);
    localparam int CW = AW - RW;

    cmdState_e       state_q, state_d;
    logic [2:0]      rgb_q, rgb_d;
    logic [5:0]      bright_q, bright_d;
    logic [7:0]      ramData_q, ramData_d;
    logic [AW-1:0]   ramAddr_q, ramAddr_d;
    logic            ramWe_q, ramWe_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [7:0]      cmdCount_q, cmdCount_d;
    logic            readyPrev_q;
    logic            ramReset_q;
    logic            byteStrobe;

    // A byte is valid on the cycle data_ready_n is seen low after being high;
    // holding it low afterwards produces no further strobes.
    assign byteStrobe = readyPrev_q & ~data_ready_n;

    // Next-state decode; every register holds unless a byte arrives, and the
    // write strobe drops back to zero on its own after one cycle.
    always_comb begin
        state_d    = state_q;
        rgb_d      = rgb_q;
        bright_d   = bright_q;
        ramData_d  = ramData_q;
        ramAddr_d  = ramAddr_q;
        ramWe_d    = 1'b0;
        row_d      = row_q;
        col_d      = col_q;
        cmdCount_d = cmdCount_q;

        if (byteStrobe) begin
            case (state_q)
                ST_IDLE: begin
                    case (data_rx)
                        CMD_RED_ON:    begin rgb_d[2] = 1'b1; cmdCount_d = cmdCount_q + 8'd1; end
                        CMD_GREEN_ON:  begin rgb_d[1] = 1'b1; cmdCount_d = cmdCount_q + 8'd1; end
                        CMD_BLUE_ON:   begin rgb_d[0] = 1'b1; cmdCount_d = cmdCount_q + 8'd1; end
                        CMD_RED_OFF:   begin rgb_d[2] = 1'b0; cmdCount_d = cmdCount_q + 8'd1; end
                        CMD_GREEN_OFF: begin rgb_d[1] = 1'b0; cmdCount_d = cmdCount_q + 8'd1; end
                        CMD_BLUE_OFF:  begin rgb_d[0] = 1'b0; cmdCount_d = cmdCount_q + 8'd1; end
                        CMD_BRIGHT:    state_d = ST_READ_ARG;
                        CMD_LINE:      state_d = ST_READ_ROW;
                        default:       ;
                    endcase
                end
                ST_READ_ARG: begin
                    bright_d   = data_rx[5:0];
                    cmdCount_d = cmdCount_q + 8'd1;
                    state_d    = ST_IDLE;
                end
                ST_READ_ROW: begin
                    // The row byte is taken modulo the panel height; columns
                    // are filled from the last byte of the row downwards.
                    row_d   = data_rx[RW-1:0];
                    col_d   = CW'(LB - 1);
                    state_d = ST_READ_DATA;
                end
                ST_READ_DATA: begin
                    ramWe_d   = 1'b1;
                    ramData_d = data_rx;
                    ramAddr_d = {row_q, col_q};
                    if (col_q == '0) begin
                        cmdCount_d = cmdCount_q + 8'd1;
                        state_d    = ST_IDLE;
                    end else begin
                        col_d = col_q - CW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers; reset abandons any command in progress.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rgb_q       <= 3'b111;
            bright_q    <= 6'b111111;
            ramData_q   <= '0;
            ramAddr_q   <= '0;
            ramWe_q     <= 1'b0;
            row_q       <= '0;
            col_q       <= CW'(LB - 1);
            cmdCount_q  <= '0;
            readyPrev_q <= 1'b1;
            ramReset_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            rgb_q       <= rgb_d;
            bright_q    <= bright_d;
            ramData_q   <= ramData_d;
            ramAddr_q   <= ramAddr_d;
            ramWe_q     <= ramWe_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cmdCount_q  <= cmdCount_d;
            readyPrev_q <= data_ready_n;
            ramReset_q  <= 1'b0;
        end
    end

    assign rgb_enable        = rgb_q;
    assign brightness_enable = bright_q;
    assign ram_data_out      = ramData_q;
    assign ram_address       = ramAddr_q;
    assign ram_write_enable  = ramWe_q;
    assign ram_clk_enable    = ~reset;
    assign ram_reset         = ramReset_q;

`ifdef DEBUGGER
    assign cmd_line_state2        = state_q;
    assign num_commands_processed = cmdCount_q;
`endif

endmodule

// File: tb/tb_control_module.sv
// ---------------------------------------------------------------------------
// tb_control_module
// Self-checking bench for control_module: directed command sequences plus a
// randomized byte stream, compared against a command-level reference model.
// ---------------------------------------------------------------------------
module tb_control_module;

    localparam int PW = 64;
    localparam int PH = 32;
    localparam int BPP = 2;
    localparam int LB = PW * BPP;
    localparam int AW = $clog2(PH) + $clog2(LB - 1);

    localparam int MODE_IDLE = 0;
    localparam int MODE_ROW  = 1;
    localparam int MODE_DATA = 2;
    localparam int MODE_ARG  = 3;

    logic          clk_in;
    logic          reset;
    logic [7:0]    data_rx;
    logic          data_ready_n;
    logic [2:0]    rgb_enable;
    logic [5:0]    brightness_enable;
    logic [7:0]    ram_data_out;
    logic [AW-1:0] ram_address;
    logic          ram_write_enable;
    logic          ram_clk_enable;
    logic          ram_reset;
`ifdef DEBUGGER
    logic [1:0]    cmd_line_state2;
    logic [7:0]    num_commands_processed;
`endif

    int compared;
    int mismatched;

    // Reference model state, kept at the level of whole commands.
    logic [2:0] mRgb;
    logic [5:0] mBright;
    logic [7:0] mCount;
    int         mMode;
    int         mRow;
    int         mRemaining;
    int         mLastAddr;
    int         mLastData;
    int         expAddrQ[$];
    int         expDataQ[$];

    control_module #(
        .PIXEL_WIDTH(PW),
        .PIXEL_HEIGHT(PH),
        .BYTES_PER_PIXEL(BPP)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .data_rx(data_rx),
        .data_ready_n(data_ready_n),
        .rgb_enable(rgb_enable),
        .brightness_enable(brightness_enable),
        .ram_data_out(ram_data_out),
        .ram_address(ram_address),
        .ram_write_enable(ram_write_enable),
        .ram_clk_enable(ram_clk_enable),
        .ram_reset(ram_reset)
`ifdef DEBUGGER
        ,
        .cmd_line_state2(cmd_line_state2),
        .num_commands_processed(num_commands_processed)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model reaction to one received byte, written from the command rules.
    task automatic modelByte(input logic [7:0] b);
        int col;
        case (mMode)
            MODE_IDLE: begin
                case (b)
                    8'h52: begin mRgb[2] = 1'b1; mCount++; end
                    8'h47: begin mRgb[1] = 1'b1; mCount++; end
                    8'h42: begin mRgb[0] = 1'b1; mCount++; end
                    8'h72: begin mRgb[2] = 1'b0; mCount++; end
                    8'h67: begin mRgb[1] = 1'b0; mCount++; end
                    8'h62: begin mRgb[0] = 1'b0; mCount++; end
                    8'h54: mMode = MODE_ARG;
                    8'h4C: mMode = MODE_ROW;
                    default: ;
                endcase
            end
            MODE_ARG: begin
                mBright = b[5:0];
                mCount++;
                mMode = MODE_IDLE;
            end
            MODE_ROW: begin
                mRow = int'(b) % PH;
                mRemaining = LB;
                mMode = MODE_DATA;
            end
            default: begin
                col = mRemaining - 1;
                mLastAddr = mRow * LB + col;
                mLastData = int'(b);
                expAddrQ.push_back(mLastAddr);
                expDataQ.push_back(mLastData);
                mRemaining--;
                if (mRemaining == 0) begin
                    mCount++;
                    mMode = MODE_IDLE;
                end
            end
        endcase
    endtask

    task automatic modelReset();
        mRgb = 3'b111;
        mBright = 6'b111111;
        mCount = 8'd0;
        mMode = MODE_IDLE;
        mRow = 0;
        mRemaining = 0;
        mLastAddr = 0;
        mLastData = 0;
        expAddrQ.delete();
        expDataQ.delete();
    endtask

    // Every write strobe must match the next write the model expects.
    always @(negedge clk_in) begin
        if (!reset && ram_write_enable) begin
            if (expAddrQ.size() == 0) begin
                checkOutput("spuriousWrite", 32'd1, 32'd0);
            end else begin
                checkOutput("writeAddr", 32'(ram_address), 32'(expAddrQ.pop_front()));
                checkOutput("writeData", 32'(ram_data_out), 32'(expDataQ.pop_front()));
            end
        end
    end

    task automatic checkSettled();
        checkOutput("rgb", 32'(rgb_enable), 32'(mRgb));
        checkOutput("bright", 32'(brightness_enable), 32'(mBright));
        checkOutput("ramWe", 32'(ram_write_enable), 32'd0);
        checkOutput("ramAddrHold", 32'(ram_address), 32'(mLastAddr));
        checkOutput("ramDataHold", 32'(ram_data_out), 32'(mLastData));
        checkOutput("ramClkEn", 32'(ram_clk_enable), 32'd1);
        checkOutput("ramReset", 32'(ram_reset), 32'd0);
        checkOutput("pendingWrites", 32'(expAddrQ.size()), 32'd0);
`ifdef DEBUGGER
        checkOutput("cmdCount", 32'(num_commands_processed), 32'(mCount));
        checkOutput("state", 32'(cmd_line_state2), 32'(mMode));
`endif
    endtask

    // One UART byte: a busy period with junk on the data lines, then the
    // byte presented with data_ready_n low for 'hold' cycles.
    task automatic applyStimulus(input logic [7:0] b, input int hold);
        @(negedge clk_in);
        data_ready_n = 1'b1;
        repeat ($urandom_range(1, 3)) begin
            data_rx = 8'($urandom);
            @(negedge clk_in);
        end
        data_rx = b;
        data_ready_n = 1'b0;
        modelByte(b);
        repeat (hold) @(negedge clk_in);
        checkSettled();
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(b, $urandom_range(2, 5));
    endtask

    task automatic doReset();
        @(negedge clk_in);
        reset = 1'b1;
        data_ready_n = 1'b1;
        repeat (2) @(negedge clk_in);
        checkOutput("rstRgb", 32'(rgb_enable), 32'h7);
        checkOutput("rstBright", 32'(brightness_enable), 32'h3F);
        checkOutput("rstWe", 32'(ram_write_enable), 32'd0);
        checkOutput("rstAddr", 32'(ram_address), 32'd0);
        checkOutput("rstData", 32'(ram_data_out), 32'd0);
        checkOutput("rstClkEn", 32'(ram_clk_enable), 32'd0);
        checkOutput("rstRamReset", 32'(ram_reset), 32'd1);
`ifdef DEBUGGER
        checkOutput("rstCount", 32'(num_commands_processed), 32'd0);
        checkOutput("rstState", 32'(cmd_line_state2), 32'd0);
`endif
        reset = 1'b0;
        modelReset();
        @(negedge clk_in);
        checkSettled();
    endtask

    task automatic sendLine(input logic [7:0] rowByte, input int nData);
        sendByte(8'h4C);
        sendByte(rowByte);
        for (int i = 0; i < nData; i++) sendByte(8'($urandom));
    endtask

    initial begin
        logic [7:0] cmdSet [8];
        int choice;
        cmdSet[0] = 8'h52; cmdSet[1] = 8'h47; cmdSet[2] = 8'h42; cmdSet[3] = 8'h72;
        cmdSet[4] = 8'h67; cmdSet[5] = 8'h62; cmdSet[6] = 8'h20; cmdSet[7] = 8'h78;

        compared = 0;
        mismatched = 0;
        reset = 1'b1;
        data_ready_n = 1'b1;
        data_rx = 8'h00;
        modelReset();

        doReset();

        // Colour plane off then on again.
        sendByte(8'h72);
        checkOutput("rgbAfter_r", 32'(rgb_enable), 32'h3);
        sendByte(8'h52);
        checkOutput("rgbAfter_R", 32'(rgb_enable), 32'h7);

        // Brightness command with argument 0x15.
        sendByte(8'h54);
        sendByte(8'h15);
        checkOutput("bright15", 32'(brightness_enable), 32'h15);

        // Full row write to row 13 ('-'), then prove the decoder is idle
        // again because a colour command takes effect.
        sendLine(8'h2D, LB);
        checkOutput("lastRowAddr", 32'(ram_address), 32'(13 * LB));
        sendByte(8'h67);
        checkOutput("rgbAfterLine", 32'(rgb_enable), 32'h5);

        // Ignored bytes.
        sendByte(8'h20);
        sendByte(8'h78);
        checkOutput("rgbIgnored", 32'(rgb_enable), 32'h5);

        // A long low period produces one action only.
        applyStimulus(8'h62, 50);
        checkOutput("rgbLongHold", 32'(rgb_enable), 32'h4);

        // Reset in the middle of a row, then non-command bytes must not write.
        sendLine(8'h2D, 10);
        doReset();
        for (int i = 0; i < 5; i++) sendByte(8'h30 + 8'(i));

        // Randomized command stream.
        for (int n = 0; n < 120; n++) begin
            choice = $urandom_range(0, 19);
            if (choice < 10) begin
                sendByte(cmdSet[$urandom_range(0, 7)]);
            end else if (choice < 14) begin
                sendByte(8'h54);
                sendByte(8'($urandom));
            end else if (choice == 14) begin
                sendLine(8'($urandom), LB);
            end else begin
                sendByte(8'($urandom));
            end
        end
        // Drain any command left half-finished by random bytes.
        while (mMode != MODE_IDLE) sendByte(8'($urandom));
        repeat (4) @(negedge clk_in);
        checkOutput("finalPending", 32'(expAddrQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
